matmul_result_collector: RTL and testbench
==========================================

Name: matmul_result_collector

Overview:
- Downstream consumer of the 2x2 systolic matmul core's two-beat result output.
- Detects a result frame when the core's output-enable rises, and rebuilds the four 8-bit C elements from the nibble-split beats.
- Buffers up to DEPTH frames and drains them as a valid/ready byte stream in order C00, C01, C10, C11.

Parameters:
- DEPTH, 2, number of 4-byte frames held in the result buffer; power of two, >=1.
- CNT_W, 4, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ena  in  1  capture enable; while low, no new frame is started (the drain still runs).
- beat_lo  in  8  core uo_out.
- beat_hi  in  8  core uio_out.
- beat_oe  in  8  core uio_oe; 8'hFF marks result beats.
- out_data  out  8  result byte.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts a byte when out_valid && out_ready.
- out_last  out  1  high with the C11 byte of each frame.
- frames_dropped  out  CNT_W  saturating count of frames lost to buffer full.
- frame_err  out  1  sticky flag: aborted frame.
- err_clr  in  1  synchronous clear of frame_err and frames_dropped.

Behaviour:
Reset (rst high, async):
- Capture FSM goes to WAIT_B1; buffer is emptied; read/write pointers are 0.
- out_data=0, out_valid=0, out_last=0, frames_dropped=0, frame_err=0.
- oe_prev is set to 8'hFF, so a beat already present at reset release is not taken as a frame start.
- Reset mid-frame or mid-drain discards everything.

Start detection:
- Frame start is the cycle where beat_oe==8'hFF and oe_prev!=8'hFF, with ena=1.
- oe_prev is registered every cycle.

Capture FSM:
- WAIT_B1: on frame start, latch C00={beat_hi[7:4],beat_lo[7:4]} and C01={beat_hi[3:0],beat_lo[3:0]}; go to WAIT_B2.
- WAIT_B2, next cycle, if beat_oe==8'hFF:
  - C10={beat_hi[7:4],beat_lo[7:4]}, C11={beat_hi[3:0],beat_lo[3:0]}.
  - The frame commits on this edge and the FSM returns to WAIT_B1.
- WAIT_B2 with beat_oe!=8'hFF: frame discarded, frame_err<=1, return to WAIT_B1.
- Element values pass through unmodified; there is no arithmetic on C.

Commit rules:
- A frame is written if the buffer holds fewer than DEPTH frames, counting a same-cycle pop of a frame's last byte as freeing a slot.
- Otherwise the frame is dropped and frames_dropped increments, saturating at all-ones.
- err_clr has priority over a same-cycle increment or set.

Drain:
- The buffer is read byte-wise: a 2-bit byte index within the head frame, plus a frame read pointer.
- out_valid=1 whenever the buffer is non-empty; out_data and out_last are driven from registered buffer contents.
- First byte latency: out_valid rises the cycle after commit, i.e. 2 cycles after frame start when the buffer was empty.
- On a handshake (out_valid && out_ready):
  - The byte index advances.
  - After C11 (out_last=1), the frame pops, the pointer wraps modulo DEPTH and the index returns to 0.
- out_data is held stable while out_valid && !out_ready.
- Simultaneous commit and pop are both honoured; occupancy is unchanged.
- Back-to-back frames are legal: the core's minimum frame spacing exceeds 2 cycles, and the FSM must be back in WAIT_B1 the cycle after commit.

Test Plan:
- Reset, then a single frame with beat1 lo=0x36, hi=0x11 and beat2 lo=0xB2, hi=0x23 (A=[[1,2],[3,4]], B=[[5,6],[7,8]]), out_ready=1:
  - bytes 0x13, 0x16, 0x2B, 0x32 on consecutive cycles;
  - out_last only on 0x32;
  - out_valid rises 2 cycles after the oe rise.
- out_ready=0 during three frames with DEPTH=2:
  - the first two frames are held;
  - frames_dropped=1;
  - releasing ready yields exactly 8 bytes in order.
- beat_oe drops to 0x00 on beat2:
  - frame_err=1 and no bytes are emitted;
  - err_clr pulse gives frame_err=0.
- Buffer full, with the last byte of the head frame accepted in the same cycle a new frame commits -> the new frame is accepted and frames_dropped is unchanged.
- ena=0 during the oe rise -> frame ignored, no error, no output; the next frame with ena=1 is captured normally.
- Assert rst mid-drain after 2 bytes -> out_valid=0 immediately (async); after release, no residual bytes; a fresh frame outputs correctly.

Source files
------------

// File: rtl/matmul_result_collector_if.sv
// Beat input bus from the systolic core plus the valid/ready result byte stream.
interface matmul_result_collector_if;
    logic [7:0] beat_lo;
    logic [7:0] beat_hi;
    logic [7:0] beat_oe;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport slave (
        input  beat_lo, beat_hi, beat_oe, out_ready,
        output out_data, out_valid, out_last
    );

    modport master (
        output beat_lo, beat_hi, beat_oe, out_ready,
        input  out_data, out_valid, out_last
    );
endinterface

// File: rtl/matmul_result_collector.sv
// Rebuilds 2x2 matmul result frames from nibble-split core beats, buffers up to
// DEPTH frames and drains them as an ordered byte stream C00, C01, C10, C11.
module matmul_result_collector #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          err_clr,
    matmul_result_collector_if.slave      bus,
    output logic [CNT_W-1:0]              frames_dropped,
    output logic                          frame_err
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    typedef enum logic {WAIT_B1, WAIT_B2} state_t;

    state_t          state, state_nxt;
    logic [7:0]      oe_prev;
    logic            start;
    logic            latch_b1, commit, abort;
    logic [7:0]      c00, c01;

    logic [3:0][7:0] mem [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [1:0]      idx;
    logic [OW-1:0]   count;

    logic            full, empty, hs, pop, can_write, write, drop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // oe_prev resets to all-ones so a beat already on the bus at release is not a start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) oe_prev <= 8'hFF;
        else     oe_prev <= bus.beat_oe;
    end

    assign start = ena && (bus.beat_oe == 8'hFF) && (oe_prev != 8'hFF);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_B1;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_B1: if (start) state_nxt = WAIT_B2;
            WAIT_B2: state_nxt = WAIT_B1;
            default: state_nxt = WAIT_B1;
        endcase
    end

    always_comb begin
        latch_b1 = 1'b0;
        commit   = 1'b0;
        abort    = 1'b0;
        unique case (state)
            WAIT_B1: latch_b1 = start;
            WAIT_B2: begin
                commit = (bus.beat_oe == 8'hFF);
                abort  = (bus.beat_oe != 8'hFF);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c00 <= '0;
            c01 <= '0;
        end else if (latch_b1) begin
            c00 <= {bus.beat_hi[7:4], bus.beat_lo[7:4]};
            c01 <= {bus.beat_hi[3:0], bus.beat_lo[3:0]};
        end
    end

    assign full      = (count == OW'(DEPTH));
    assign empty     = (count == '0);
    assign hs        = bus.out_valid && bus.out_ready;
    assign pop       = hs && (idx == 2'd3);
    // Popping the head's last byte frees its slot on the same edge the new frame lands
    assign can_write = !full || pop;
    assign write     = commit && can_write;
    assign drop      = commit && !can_write;

    always_ff @(posedge clk) begin
        if (write)
            mem[wr_ptr] <= {{bus.beat_hi[3:0], bus.beat_lo[3:0]},
                            {bus.beat_hi[7:4], bus.beat_lo[7:4]}, c01, c00};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            idx    <= '0;
            count  <= '0;
        end else begin
            if (write) wr_ptr <= next_ptr(wr_ptr);
            if (hs)    idx    <= idx + 2'd1;
            if (pop)   rd_ptr <= next_ptr(rd_ptr);
            unique case ({write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frames_dropped <= '0;
            frame_err      <= 1'b0;
        end else if (err_clr) begin
            frames_dropped <= '0;
            frame_err      <= 1'b0;
        end else begin
            if (drop && (frames_dropped != '1)) frames_dropped <= frames_dropped + 1'b1;
            if (abort) frame_err <= 1'b1;
        end
    end

    always_comb begin
        bus.out_valid = !empty;
        bus.out_data  = empty ? '0 : mem[rd_ptr][idx];
        bus.out_last  = !empty && (idx == 2'd3);
    end
endmodule

// File: tb/tb_matmul_result_collector.sv
// Scoreboard bench: directed frames push expected bytes; a monitor pops on each handshake.
module tb_matmul_result_collector;
    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       err_clr;
    logic [3:0] frames_dropped;
    logic       frame_err;

    int vectors = 0;
    int errs = 0;
    int bytes_seen = 0;
    logic [8:0] exp_q[$];

    matmul_result_collector_if bus ();

    matmul_result_collector #(.DEPTH(2), .CNT_W(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ena            (ena),
        .err_clr        (err_clr),
        .bus            (bus.slave),
        .frames_dropped (frames_dropped),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back({1'b0, b0});
        exp_q.push_back({1'b0, b1});
        exp_q.push_back({1'b0, b2});
        exp_q.push_back({1'b1, b3});
    endtask

    task automatic monitor();
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (!rst && bus.out_valid && bus.out_ready) begin
                bytes_seen++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    errs++;
                    $display("FAIL unexpected_byte: got data 0x%0h last %0b, expected no byte",
                             bus.out_data, bus.out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
                    chk("out_last", {31'd0, bus.out_last}, {31'd0, e[8]});
                end
            end
        end
    endtask

    task automatic send_frame(input logic [7:0] lo1, input logic [7:0] hi1,
                              input logic [7:0] lo2, input logic [7:0] hi2,
                              input logic [7:0] oe2, input logic en1);
        @(posedge clk); #1;
        ena = en1; bus.beat_oe = 8'hFF; bus.beat_lo = lo1; bus.beat_hi = hi1;
        @(posedge clk); #1;
        ena = 1'b1; bus.beat_oe = oe2; bus.beat_lo = lo2; bus.beat_hi = hi2;
        @(posedge clk); #1;
        bus.beat_oe = 8'h00; bus.beat_lo = 8'h00; bus.beat_hi = 8'h00;
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk(name, {31'd0, exp_q.size() == 0}, 32'd1);
        repeat (6) @(posedge clk);
        #1;
    endtask

    initial begin
        int base;
        rst = 1'b1; ena = 1'b1; err_clr = 1'b0;
        bus.beat_lo = '0; bus.beat_hi = '0; bus.beat_oe = '0; bus.out_ready = 1'b1;
        fork monitor(); join_none

        // Reset state
        repeat (2) @(posedge clk); #1;
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", {24'd0, bus.out_data}, 32'd0);
        chk("rst_last", {31'd0, bus.out_last}, 32'd0);
        chk("rst_dropped", {28'd0, frames_dropped}, 32'd0);
        chk("rst_err", {31'd0, frame_err}, 32'd0);
        rst = 1'b0;

        // Single frame with latency check
        push_frame(8'h13, 8'h16, 8'h2B, 8'h32);
        @(posedge clk); #1;
        bus.beat_oe = 8'hFF; bus.beat_lo = 8'h36; bus.beat_hi = 8'h11;
        @(posedge clk); #1;
        chk("lat_valid_b1", {31'd0, bus.out_valid}, 32'd0);
        bus.beat_lo = 8'hB2; bus.beat_hi = 8'h23;
        @(posedge clk); #1;
        chk("lat_valid_commit", {31'd0, bus.out_valid}, 32'd1);
        chk("lat_first_byte", {24'd0, bus.out_data}, 32'h13);
        bus.beat_oe = 8'h00; bus.beat_lo = 8'h00; bus.beat_hi = 8'h00;
        wait_drain("drain_single");

        // Three frames while stalled: two held, one dropped
        bus.out_ready = 1'b0;
        push_frame(8'h13, 8'h16, 8'h2B, 8'h32);
        push_frame(8'h42, 8'h31, 8'h86, 8'h75);
        send_frame(8'h36, 8'h11, 8'hB2, 8'h23, 8'hFF, 1'b1);
        send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'hFF, 1'b1);
        send_frame(8'hF0, 8'h0F, 8'hAA, 8'h55, 8'hFF, 1'b1);
        #1;
        chk("full_dropped", {28'd0, frames_dropped}, 32'd1);
        chk("stall_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("stall_hold_data", {24'd0, bus.out_data}, 32'h13);
        base = bytes_seen;
        bus.out_ready = 1'b1;
        wait_drain("drain_full");
        chk("full_byte_count", bytes_seen - base, 32'd8);

        // Aborted frame
        send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'h00, 1'b1);
        repeat (3) @(posedge clk); #1;
        chk("abort_err", {31'd0, frame_err}, 32'd1);
        chk("abort_no_valid", {31'd0, bus.out_valid}, 32'd0);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        chk("clr_err", {31'd0, frame_err}, 32'd0);
        chk("clr_dropped", {28'd0, frames_dropped}, 32'd0);

        // Full buffer; head's last byte pops on the same edge a new frame commits
        bus.out_ready = 1'b0;
        push_frame(8'h13, 8'h16, 8'h2B, 8'h32);
        push_frame(8'h42, 8'h31, 8'h86, 8'h75);
        push_frame(8'h0F, 8'hF0, 8'h5A, 8'h5A);
        send_frame(8'h36, 8'h11, 8'hB2, 8'h23, 8'hFF, 1'b1);
        send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'hFF, 1'b1);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.beat_oe = 8'hFF; bus.beat_lo = 8'hF0; bus.beat_hi = 8'h0F;
        @(posedge clk); #1;
        bus.beat_lo = 8'hAA; bus.beat_hi = 8'h55;
        @(posedge clk); #1;
        bus.beat_oe = 8'h00; bus.beat_lo = 8'h00; bus.beat_hi = 8'h00;
        wait_drain("drain_simul");
        chk("simul_dropped", {28'd0, frames_dropped}, 32'd0);

        // ena low during oe rise: ignored; next frame captured
        send_frame(8'h21, 8'h43, 8'h65, 8'h87, 8'hFF, 1'b0);
        repeat (4) @(posedge clk); #1;
        chk("ena_no_err", {31'd0, frame_err}, 32'd0);
        chk("ena_no_valid", {31'd0, bus.out_valid}, 32'd0);
        push_frame(8'hE9, 8'h7C, 8'hF0, 8'hF0);
        send_frame(8'h9C, 8'hE7, 8'h00, 8'hFF, 8'hFF, 1'b1);
        wait_drain("drain_ena");

        // Reset mid-drain after two bytes
        exp_q.push_back({1'b0, 8'h13});
        exp_q.push_back({1'b0, 8'h16});
        @(posedge clk); #1;
        bus.beat_oe = 8'hFF; bus.beat_lo = 8'h36; bus.beat_hi = 8'h11;
        @(posedge clk); #1;
        bus.beat_lo = 8'hB2; bus.beat_hi = 8'h23;
        @(posedge clk); #1;
        bus.beat_oe = 8'h00; bus.beat_lo = 8'h00; bus.beat_hi = 8'h00;
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_bytes_taken", {31'd0, exp_q.size() == 0}, 32'd1);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk); #1;
        chk("postrst_valid", {31'd0, bus.out_valid}, 32'd0);
        push_frame(8'h13, 8'h16, 8'h2B, 8'h32);
        send_frame(8'h36, 8'h11, 8'hB2, 8'h23, 8'hFF, 1'b1);
        wait_drain("drain_postrst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
